// File: rtl/fp_result_queue.sv
// Circular result queue between the FP multiply-add stage and FP regfile writeback; head visible one cycle after enqueue.
// Backpressure: enqReady drops only when full (a same-cycle dequeue does not free a slot); fflags accumulate on dequeue.
module fp_result_queue #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enqValid,
  output logic                         enqReady,
  input  logic [4:0]                   enqRd,
  input  logic [31:0]                  enqResult,
  input  logic [4:0]                   enqFlags,
  output logic                         deqValid,
  input  logic                         deqReady,
  output logic [4:0]                   deqRd,
  output logic [31:0]                  deqResult,
  output logic [4:0]                   deqFlags,
  output logic [4:0]                   accumFlags,
  input  logic                         clearFlags,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] result;
    logic [4:0]  flags;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic          enqFire;
  logic          deqFire;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake flags depend only on registered occupancy, never on the opposite side's handshake.
  assign enqReady = (count < FULL);
  assign deqValid = (count != '0);
  assign enqFire  = enqValid && enqReady && !flush;
  assign deqFire  = deqValid && deqReady && !flush;

  assign head      = mem[rdPtr];
  assign deqRd     = head.rd;
  assign deqResult = head.result;
  assign deqFlags  = head.flags;

  // Payload storage is never cleared; count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (!rst && enqFire) begin
      mem[wrPtr] <= '{rd: enqRd, result: enqResult, flags: enqFlags};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      rdPtr      <= '0;
      wrPtr      <= '0;
      accumFlags <= '0;
    end else begin
      // A CSR clear lands before the OR of the flags being retired this cycle.
      if (clearFlags) begin
        accumFlags <= deqFire ? deqFlags : 5'd0;
      end else if (deqFire) begin
        accumFlags <= accumFlags | deqFlags;
      end

      if (flush) begin
        count <= '0;
        rdPtr <= '0;
        wrPtr <= '0;
      end else begin
        if (enqFire) wrPtr <= nextPtr(wrPtr);
        if (deqFire) rdPtr <= nextPtr(rdPtr);
        if (enqFire && !deqFire) begin
          count <= count + CW'(1);
        end else if (!enqFire && deqFire) begin
          count <= count - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_result_queue.sv
// Bench for fp_result_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_fp_result_queue;

  localparam int D = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] res;
    logic [4:0]  fl;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enqValid = 1'b0;
  logic        enqReady;
  logic [4:0]  enqRd = '0;
  logic [31:0] enqResult = '0;
  logic [4:0]  enqFlags = '0;
  logic        deqValid;
  logic        deqReady = 1'b0;
  logic [4:0]  deqRd;
  logic [31:0] deqResult;
  logic [4:0]  deqFlags;
  logic [4:0]  accumFlags;
  logic        clearFlags = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  count;

  ent_t        mq[$];
  logic [4:0]  macc = '0;
  int          total = 0;
  int          bad = 0;

  fp_result_queue #(.DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .enqValid(enqValid), .enqReady(enqReady), .enqRd(enqRd), .enqResult(enqResult), .enqFlags(enqFlags),
    .deqValid(deqValid), .deqReady(deqReady), .deqRd(deqRd), .deqResult(deqResult), .deqFlags(deqFlags),
    .accumFlags(accumFlags), .clearFlags(clearFlags), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  function automatic ent_t rand_ent();
    ent_t e;
    e.rd  = 5'($urandom);
    e.res = $urandom;
    e.fl  = 5'($urandom);
    return e;
  endfunction

  task automatic drive_enq(input ent_t e);
    enqValid  = 1'b1;
    enqRd     = e.rd;
    enqResult = e.res;
    enqFlags  = e.fl;
  endtask

  task automatic idle();
    rst = 1'b0; enqValid = 1'b0; deqReady = 1'b0; clearFlags = 1'b0; flush = 1'b0;
  endtask

  // Advances one clock; the model decides from the inputs and its own state before the edge.
  task automatic tick();
    bit ef, df;
    logic [4:0] nacc;
    ent_t e;
    e    = '{rd: enqRd, res: enqResult, fl: enqFlags};
    ef   = enqValid && (mq.size() < D) && !flush;
    df   = (mq.size() != 0) && deqReady && !flush;
    nacc = clearFlags ? 5'd0 : macc;
    if (df) nacc = nacc | mq[0].fl;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      macc = '0;
    end else begin
      macc = nacc;
      if (flush) mq.delete();
      else begin
        if (df) void'(mq.pop_front());
        if (ef) mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enqValid = 1'b1; deqReady = 1'b1; flush = 1'b1; clearFlags = 1'b0;
    tick(); tick();
    idle();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (deqValid !== 1'b0) begin bad++; $display("FAIL reset_deqValid: got %b want 0", deqValid); end
    total++; if (enqReady !== 1'b1) begin bad++; $display("FAIL reset_enqReady: got %b want 1", enqReady); end
    total++; if (accumFlags !== 5'd0) begin bad++; $display("FAIL reset_accum: got %h want 0", accumFlags); end
  endtask

  task automatic test_single();
    drive_enq('{rd: 5'd3, res: 32'h3F800000, fl: 5'h01});
    total++; if (deqValid !== 1'b0) begin bad++; $display("FAIL single_no_bypass: got %b want 0", deqValid); end
    tick();
    enqValid = 1'b0;
    total++; if (deqValid !== 1'b1) begin bad++; $display("FAIL single_deqValid: got %b want 1", deqValid); end
    total++; if (deqRd !== 5'd3) begin bad++; $display("FAIL single_rd: got %0d want 3", deqRd); end
    total++; if (deqResult !== 32'h3F800000) begin bad++; $display("FAIL single_result: got %h want 3f800000", deqResult); end
    total++; if (deqFlags !== 5'h01) begin bad++; $display("FAIL single_flags: got %h want 01", deqFlags); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count: got %0d want 1", count); end
    total++; if (accumFlags !== 5'd0) begin bad++; $display("FAIL single_accum: got %h want 0", accumFlags); end
    tick();
    total++; if ({deqRd, deqResult} !== {5'd3, 32'h3F800000}) begin bad++; $display("FAIL single_hold: got %h/%h want 3/3f800000", deqRd, deqResult); end
    deqReady = 1'b1;
    tick();
    deqReady = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL single_drain_count: got %0d want 0", count); end
    total++; if (accumFlags !== 5'h01) begin bad++; $display("FAIL single_drain_accum: got %h want 01", accumFlags); end
  endtask

  task automatic test_fill();
    ent_t exp [5];
    for (int i = 0; i < 5; i++) exp[i] = rand_ent();
    for (int i = 0; i < 5; i++) begin
      drive_enq(exp[i]);
      tick();
      total++; if (count !== 3'((i < 4) ? i + 1 : 4)) begin bad++; $display("FAIL fill_count%0d: got %0d want %0d", i, count, (i < 4) ? i + 1 : 4); end
      total++; if (enqReady !== ((i >= 3) ? 1'b0 : 1'b1)) begin bad++; $display("FAIL fill_enqReady%0d: got %b want %b", i, enqReady, (i < 3)); end
    end
    enqValid = 1'b0;
    deqReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if ({deqValid, deqRd, deqResult, deqFlags} !== {1'b1, exp[i]}) begin
        bad++; $display("FAIL drain_head%0d: got v=%b %h/%h/%h want %h/%h/%h", i, deqValid, deqRd, deqResult, deqFlags, exp[i].rd, exp[i].res, exp[i].fl);
      end
      tick();
    end
    deqReady = 1'b0;
    total++; if (count !== 3'd0 || deqValid !== 1'b0) begin bad++; $display("FAIL drain_empty: got count=%0d v=%b want 0/0", count, deqValid); end
  endtask

  task automatic test_full_simul();
    ent_t exp [4];
    for (int i = 0; i < 4; i++) begin
      exp[i] = rand_ent();
      drive_enq(exp[i]);
      tick();
    end
    drive_enq(rand_ent());
    deqReady = 1'b1;
    tick();
    enqValid = 1'b0;
    deqReady = 1'b0;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL fullsim_count: got %0d want 3", count); end
    total++; if (enqReady !== 1'b1) begin bad++; $display("FAIL fullsim_enqReady: got %b want 1", enqReady); end
    deqReady = 1'b1;
    for (int i = 1; i < 4; i++) begin
      total++; if ({deqRd, deqResult, deqFlags} !== exp[i]) begin bad++; $display("FAIL fullsim_head%0d: got %h/%h want %h/%h", i, deqRd, deqResult, exp[i].rd, exp[i].res); end
      tick();
    end
    deqReady = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL fullsim_empty: got %0d want 0", count); end
  endtask

  task automatic test_flags();
    logic [4:0] fl [3];
    fl[0] = 5'h10; fl[1] = 5'h04; fl[2] = 5'h01;
    clearFlags = 1'b1;
    tick();
    clearFlags = 1'b0;
    total++; if (accumFlags !== 5'd0) begin bad++; $display("FAIL flags_clear: got %h want 0", accumFlags); end
    for (int i = 0; i < 3; i++) begin
      drive_enq('{rd: 5'(i), res: $urandom, fl: fl[i]});
      tick();
    end
    enqValid = 1'b0;
    deqReady = 1'b1;
    tick();
    total++; if (accumFlags !== 5'h10) begin bad++; $display("FAIL flags_first: got %h want 10", accumFlags); end
    tick();
    total++; if (accumFlags !== 5'h14) begin bad++; $display("FAIL flags_second: got %h want 14", accumFlags); end
    clearFlags = 1'b1;
    tick();
    clearFlags = 1'b0;
    deqReady = 1'b0;
    total++; if (accumFlags !== 5'h01) begin bad++; $display("FAIL flags_clear_deq: got %h want 01", accumFlags); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL flags_count: got %0d want 0", count); end
  endtask

  task automatic test_flush();
    ent_t fresh;
    clearFlags = 1'b1;
    tick();
    clearFlags = 1'b0;
    drive_enq('{rd: 5'd7, res: 32'h40000000, fl: 5'h02});
    tick();
    enqValid = 1'b0;
    deqReady = 1'b1;
    tick();
    deqReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_enq(rand_ent());
      tick();
    end
    enqValid = 1'b0;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL flush_pre_count: got %0d want 3", count); end
    drive_enq(rand_ent());
    flush = 1'b1;
    deqReady = 1'b1;
    tick();
    flush = 1'b0; enqValid = 1'b0; deqReady = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_count: got %0d want 0", count); end
    total++; if (deqValid !== 1'b0) begin bad++; $display("FAIL flush_deqValid: got %b want 0", deqValid); end
    total++; if (accumFlags !== 5'h02) begin bad++; $display("FAIL flush_accum: got %h want 02", accumFlags); end
    tick();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_dropped: got %0d want 0", count); end
    fresh = rand_ent();
    drive_enq(fresh);
    tick();
    enqValid = 1'b0;
    total++; if (count !== 3'd1 || {deqRd, deqResult, deqFlags} !== fresh) begin
      bad++; $display("FAIL flush_after: got count=%0d %h/%h want 1 %h/%h", count, deqRd, deqResult, fresh.rd, fresh.res);
    end
    deqReady = 1'b1;
    tick();
    deqReady = 1'b0;
  endtask

  task automatic test_stream();
    ent_t exp [10];
    int   outs = 0;
    for (int i = 0; i < 10; i++) exp[i] = rand_ent();
    deqReady = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) drive_enq(exp[i]);
      else enqValid = 1'b0;
      if (deqValid) outs++;
      tick();
      if (i < 10) begin
        total++; if (count !== 3'd1) begin bad++; $display("FAIL stream_count%0d: got %0d want 1", i, count); end
        total++; if ({deqValid, deqRd, deqResult, deqFlags} !== {1'b1, exp[i]}) begin
          bad++; $display("FAIL stream_head%0d: got v=%b %h/%h want %h/%h", i, deqValid, deqRd, deqResult, exp[i].rd, exp[i].res);
        end
      end
    end
    deqReady = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL stream_end_count: got %0d want 0", count); end
    total++; if (outs != 10) begin bad++; $display("FAIL stream_throughput: got %0d want 10", outs); end
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) begin
      drive_enq(rand_ent());
      tick();
    end
    enqValid = 1'b0;
    deqReady = 1'b1;
    tick();
    rst = 1'b1; drive_enq(rand_ent()); flush = 1'b1; clearFlags = 1'b1;
    tick();
    idle();
    total++; if (count !== 3'd0 || deqValid !== 1'b0) begin bad++; $display("FAIL midrst_empty: got count=%0d v=%b want 0/0", count, deqValid); end
    total++; if (accumFlags !== 5'd0) begin bad++; $display("FAIL midrst_accum: got %h want 0", accumFlags); end
    total++; if (enqReady !== 1'b1) begin bad++; $display("FAIL midrst_enqReady: got %b want 1", enqReady); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 63) == 0);
      flush      = ($urandom_range(0, 31) == 0);
      clearFlags = ($urandom_range(0, 15) == 0);
      deqReady   = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) != 0) drive_enq(rand_ent());
      else enqValid = 1'b0;
      tick();
      total++; if (count !== 3'(mq.size())) begin bad++; $display("FAIL rand_count@%0d: got %0d want %0d", n, count, mq.size()); end
      total++; if (deqValid !== (mq.size() != 0)) begin bad++; $display("FAIL rand_deqValid@%0d: got %b want %b", n, deqValid, mq.size() != 0); end
      total++; if (enqReady !== (mq.size() < D)) begin bad++; $display("FAIL rand_enqReady@%0d: got %b want %b", n, enqReady, mq.size() < D); end
      total++; if (accumFlags !== macc) begin bad++; $display("FAIL rand_accum@%0d: got %h want %h", n, accumFlags, macc); end
      if (mq.size() != 0) begin
        total++; if ({deqRd, deqResult, deqFlags} !== mq[0]) begin
          bad++; $display("FAIL rand_head@%0d: got %h/%h/%h want %h/%h/%h", n, deqRd, deqResult, deqFlags, mq[0].rd, mq[0].res, mq[0].fl);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_simul();
    test_flags();
    test_flush();
    test_stream();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_result_queue.md
FP_RESULT_QUEUE -- requirements
Module: FpResultQueue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, number of result entries; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-004 The block SHALL have port enqValid, input, 1, the FP multiply-add stage presents a completed result.
REQ-005 The block SHALL have port enqReady, output, 1, the queue accepts an entry this cycle.
REQ-006 The block SHALL have port enqRd, input, 5, destination FP register index.
REQ-007 The block SHALL have port enqResult, input, 32, single-precision result bits.
REQ-008 The block SHALL have port enqFlags, input, 5, fflags {NV,DZ,OF,UF,NX} produced with the result.
REQ-009 The block SHALL have port deqValid, output, 1, the head entry is valid for writeback.
REQ-010 The block SHALL have port deqReady, input, 1, the FP register-file writeback port consumes the head.
REQ-011 The block SHALL have ports deqRd (5), deqResult (32) and deqFlags (5), all outputs, carrying the head entry fields.
REQ-012 The block SHALL have port accumFlags, output, 5, sticky OR of the flags of all dequeued entries, destined for fcsr.fflags.
REQ-013 The block SHALL have port clearFlags, input, 1, zeroes accumFlags (CSR write to fflags/fcsr).
REQ-014 The block SHALL have port flush, input, 1, discards all queued entries (pipeline flush).
REQ-015 The block SHALL have port count, output, $clog2(DEPTH+1), current occupancy.

Function
REQ-016 The block SHALL store entries in a circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-017 The block SHALL drive enqReady = (count < DEPTH), from registered state only; a full queue SHALL NOT accept an entry even when a dequeue occurs in the same cycle.
REQ-018 The block SHALL enqueue when enqValid && enqReady && !flush: write {enqRd, enqResult, enqFlags} at the write pointer, then advance it.
REQ-019 The block SHALL drive deqValid = (count != 0), with deq* fields read from the entry at the read pointer; deq* fields are don't-care while deqValid is 0.
REQ-020 The block SHALL dequeue when deqValid && deqReady && !flush, advancing the read pointer.
REQ-021 The block SHALL provide no empty-queue bypass: an entry enqueued in cycle N SHALL first appear on deqValid in cycle N+1.
REQ-022 On a simultaneous enqueue and dequeue, count SHALL stay unchanged; enqueue alone SHALL increment count, and dequeue alone SHALL decrement it.
REQ-023 Head fields SHALL remain stable while deqValid && !deqReady.
REQ-024 On dequeue, accumFlags SHALL be updated to accumFlags | deqFlags at the next edge.
REQ-025 When clearFlags=1 without a dequeue, accumFlags SHALL become 0; when clearFlags coincides with a dequeue, accumFlags SHALL become deqFlags (clear applies first, then OR).
REQ-026 When flush=1, the block SHALL set count and both pointers to 0 at the next edge, ignore enqueue and dequeue in that cycle, and leave accumFlags unaffected apart from clearFlags.
REQ-027 With deqReady held at 1 and no stalls, the block SHALL sustain one enqueue and one dequeue per cycle.
REQ-028 Data written to storage SHALL not be cleared by flush or reset; validity SHALL be governed by count alone.

Reset
REQ-029 While rst=1 at an edge, the block SHALL set count=0, read pointer=0, write pointer=0 and accumFlags=0; it SHALL then drive deqValid=0 and enqReady=1.
REQ-030 rst SHALL take priority over flush, clearFlags, enqueue and dequeue, and reset mid-operation SHALL discard all entries.
REQ-031 The block SHALL accept an enqueue in the first cycle after rst deasserts.

Verification
REQ-032 Bench SHALL cover: after reset, enqueue {rd=3, result=0x3F800000, flags=0x01} with deqReady=0 -> next cycle deqValid=1, deqRd=3, deqResult=0x3F800000, count=1, accumFlags=0.
REQ-033 Bench SHALL cover: DEPTH=4, five back-to-back enqueues with deqReady=0 -> count=4, enqReady=0 after the 4th, 5th not stored; then drain -> four entries out in FIFO order.
REQ-034 Bench SHALL cover: full queue with enqValid=1 and deqReady=1 in the same cycle -> dequeue only, count 4->3, enqReady=1 next cycle.
REQ-035 Bench SHALL cover: dequeue entries with flags 0x10 then 0x04 -> accumFlags 0x10 then 0x14; clearFlags together with a dequeue of flags 0x01 -> accumFlags=0x01.
REQ-036 Bench SHALL cover: 3 entries queued with accumFlags=0x02, assert flush with enqValid=1 -> count=0, deqValid=0, accumFlags=0x02, enqueued entry dropped.
REQ-037 Bench SHALL cover: 10 entries streamed with deqReady=1, wrapping the pointers twice -> order preserved, count never exceeds 1, one result per cycle.
